// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, defaults and width helper for the FIR MAC sequencer
package fir_pkg;

    localparam int TAPS_DEF = 16;
    localparam int DW_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RUN,
        DRAIN,
        DONE
    } fir_sched_state_t;

    // Address width for a TAPS-deep RAM/ROM, never narrower than one bit.
    function automatic int aw_of(input int taps);
        return (taps <= 2) ? 1 : $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// rtl/fir_mac_sched_if.sv - strobe input and delay-line/ROM/MAC control bundle
interface fir_mac_sched_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          st_in;
    logic [DW-1:0] din;
    logic          ovr_clr;
    logic          dl_we;
    logic [AW-1:0] dl_waddr;
    logic [DW-1:0] dl_wdata;
    logic [AW-1:0] dl_raddr;
    logic [AW-1:0] cf_raddr;
    logic          mac_clr;
    logic          mac_en;
    logic          mac_last;
    logic          dout_vld;
    logic          busy;
    logic          warm;
    logic          overrun;

    modport master (
        input  st_in, din, ovr_clr,
        output dl_we, dl_waddr, dl_wdata, dl_raddr, cf_raddr,
               mac_clr, mac_en, mac_last, dout_vld, busy, warm, overrun
    );

    modport slave (
        output st_in, din, ovr_clr,
        input  dl_we, dl_waddr, dl_wdata, dl_raddr, cf_raddr,
               mac_clr, mac_en, mac_last, dout_vld, busy, warm, overrun
    );
endinterface

// File: rtl/fir_addr_gen.sv
// rtl/fir_addr_gen.sv - modular write-pointer increment and (wr_ptr - k) mod TAPS
module fir_addr_gen #(
    parameter int TAPS = 16,
    parameter int AW   = 4
) (
    input  logic [AW-1:0] wr_ptr,
    input  logic [AW-1:0] k,
    output logic [AW-1:0] wr_ptr_inc,
    output logic [AW-1:0] rd_addr
);
    logic [AW:0] diff;

    assign wr_ptr_inc = (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + AW'(1);

    // One extra bit catches the borrow; adding TAPS back handles any TAPS, not just powers of 2.
    assign diff    = {1'b0, wr_ptr} - {1'b0, k};
    assign rd_addr = diff[AW] ? AW'(diff + (AW+1)'(TAPS)) : diff[AW-1:0];
endmodule

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - single-MAC FIR sequencer; FIR_SMPL_HOLD_EN adds a one-entry strobe hold
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = aw_of(TAPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_mac_sched_if.master       bus
);
    localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(TAPS);
    localparam logic [AW:0]   FILL_PRE = (AW+1)'(TAPS - 1);

    fir_sched_state_t state, state_nxt;
    logic [AW-1:0]    wr_ptr, wr_ptr_inc, k, rd_addr;
    logic [AW:0]      fill;
    logic [DW-1:0]    sample;
    logic             mac_en_q, mac_last_q, overrun_q;
    logic             run, k_last, busy_i, accept, reload, ovr_set;

    assign run    = (state == RUN);
    assign k_last = (k == K_LAST);
    assign busy_i = (state == WRITE) || run || (state == DRAIN);

`ifdef FIR_SMPL_HOLD_EN
    logic          hold_vld;
    logic [DW-1:0] hold_data;

    assign reload  = (state == DONE) && hold_vld;
    assign accept  = bus.st_in && ((state == IDLE) || ((state == DONE) && !hold_vld));
    assign ovr_set = bus.st_in && hold_vld && (busy_i || (state == DONE));
`else
    assign reload  = 1'b0;
    assign accept  = bus.st_in && ((state == IDLE) || (state == DONE));
    assign ovr_set = bus.st_in && busy_i;
`endif

    fir_addr_gen #(.TAPS(TAPS), .AW(AW)) u_addr (
        .wr_ptr     (wr_ptr),
        .k          (k),
        .wr_ptr_inc (wr_ptr_inc),
        .rd_addr    (rd_addr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = RUN;
            RUN:     if (k_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = (accept || reload) ? WRITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            k          <= '0;
            fill       <= '0;
            sample     <= '0;
            mac_en_q   <= 1'b0;
            mac_last_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef FIR_SMPL_HOLD_EN
            hold_vld   <= 1'b0;
            hold_data  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            // MAC controls trail the addresses by the 1-cycle RAM/ROM read latency.
            mac_en_q   <= run;
            mac_last_q <= run && k_last;
            k          <= (run && !k_last) ? k + AW'(1) : '0;
            if (accept) sample <= bus.din;
`ifdef FIR_SMPL_HOLD_EN
            else if (reload) sample <= hold_data;
            if (reload) hold_vld <= 1'b0;
            else if (bus.st_in && busy_i && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_data <= bus.din;
            end
`endif
            if (state == DONE) begin
                wr_ptr <= wr_ptr_inc;
                if (fill != FILL_MAX) fill <= fill + (AW+1)'(1);
            end
            if (ovr_set)          overrun_q <= 1'b1;
            else if (bus.ovr_clr) overrun_q <= 1'b0;
        end
    end

    assign bus.dl_we    = (state == WRITE);
    assign bus.dl_waddr = (state == WRITE) ? wr_ptr : '0;
    assign bus.dl_wdata = (state == WRITE) ? sample : '0;
    assign bus.dl_raddr = run ? rd_addr : '0;
    assign bus.cf_raddr = run ? k : '0;
    assign bus.mac_clr  = (state == WRITE);
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_last = mac_last_q;
    assign bus.dout_vld = (state == DONE);
    assign bus.busy     = busy_i;
    // Warm already shows in the DONE cycle that completes the TAPS-th sample.
    assign bus.warm     = (fill == FILL_MAX) || ((state == DONE) && (fill == FILL_PRE));
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb/tb_fir_mac_sched.sv - scoreboard bench for fir_mac_sched at TAPS=5
module tb_fir_mac_sched;
    localparam int TAPS = 5;

    typedef struct {
        int          wcyc;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        bit          warm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    logic rst_q = 1'b0;
    int   tests = 0;
    int   fails = 0;

    exp_t wq[$];
    exp_t cur;
    bit   active = 1'b0;
    int   base = 0;
    int   m_ptr = 0;
    int   m_fill = 0;
    int   last_wcyc = 0;
    bit   exp_ovr = 1'b0;

    fir_mac_sched_if #(.DW(16), .AW(3)) bus ();

    fir_mac_sched #(.TAPS(TAPS), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= !reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int i;
        int ea;
        if (rst_q) begin
            check("reset_outputs", {bus.dl_we, bus.dl_waddr, bus.dl_wdata, bus.dl_raddr, bus.cf_raddr,
                  bus.mac_clr, bus.mac_en, bus.mac_last, bus.dout_vld, bus.busy, bus.warm, bus.overrun}, 0);
            active = 1'b0;
        end else begin
            if (bus.dl_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cur = wq.pop_front();
                    check("write_cycle", cyc, cur.wcyc);
                    check("dl_waddr", bus.dl_waddr, cur.waddr);
                    check("dl_wdata", bus.dl_wdata, cur.wdata);
                    active = 1'b1;
                    base   = cyc;
                end
            end
            if (active) begin
                i = cyc - base;
                if (i >= 1 && i <= TAPS) begin
                    ea = (int'(cur.waddr) - (i - 1) + TAPS) % TAPS;
                    check("dl_raddr", bus.dl_raddr, ea);
                    check("cf_raddr", bus.cf_raddr, i - 1);
                end
                check("mac_clr", bus.mac_clr, i == 0);
                check("mac_en", bus.mac_en, (i >= 2) && (i <= TAPS + 1));
                check("mac_last", bus.mac_last, i == TAPS + 1);
                check("dout_vld", bus.dout_vld, i == TAPS + 2);
                check("busy", bus.busy, i <= TAPS + 1);
                if (i == TAPS + 2) begin
                    check("warm", bus.warm, cur.warm);
                    active = 1'b0;
                end
            end else begin
                check("idle_quiet", {bus.dout_vld, bus.busy, bus.mac_en, bus.mac_clr}, 0);
            end
            check("overrun", bus.overrun, exp_ovr);
        end
    end

    task automatic push(input logic [15:0] d, input int wc);
        exp_t e;
        e.wcyc  = wc;
        e.waddr = 3'(m_ptr);
        e.wdata = d;
        m_fill  = (m_fill < TAPS) ? m_fill + 1 : TAPS;
        e.warm  = (m_fill == TAPS);
        m_ptr   = (m_ptr + 1) % TAPS;
        last_wcyc = wc;
        wq.push_back(e);
    endtask

    // mode 0: accepted now, 1: dropped with overrun, 2: held until the current DONE
    task automatic strobe(input logic [15:0] d, input int mode, input bit clr);
        int n;
        n = cyc;
        bus.st_in   = 1'b1;
        bus.din     = d;
        bus.ovr_clr = clr;
        if (mode == 0) push(d, n + 1);
        else if (mode == 2) push(d, last_wcyc + TAPS + 3);
        @(posedge clk); #1;
        bus.st_in   = 1'b0;
        bus.din     = '0;
        bus.ovr_clr = 1'b0;
        if (mode == 1) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        idle(n);
        reset   = 1'b1;
        m_ptr   = 0;
        m_fill  = 0;
        exp_ovr = 1'b0;
        wq.delete();
    endtask

    initial begin
        logic [15:0] six [6];
        six = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000, 16'h00FF, 16'hABCD};
        bus.st_in   = 1'b0;
        bus.din     = '0;
        bus.ovr_clr = 1'b0;
        #1;
        do_reset(3);
        idle(5);

        // Spacing TAPS+3: each later strobe lands on the previous DONE; pointer wraps on the fifth.
        for (int s = 0; s < 6; s++) begin
            strobe(six[s], 0, 1'b0);
            idle(TAPS + 2);
        end
        idle(6);

        strobe(16'h00A0, 0, 1'b0);
        idle(3);
`ifdef FIR_SMPL_HOLD_EN
        strobe(16'h00B0, 2, 1'b0);
        idle(1);
        strobe(16'h00C0, 1, 1'b0);
`else
        strobe(16'h00B0, 1, 1'b0);
        idle(1);
        strobe(16'h00C0, 1, 1'b1);
`endif
        idle(20);
        bus.ovr_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        idle(3);

        strobe(16'h5A5A, 0, 1'b0);
        idle(3);
        do_reset(1);
        idle(2);
        strobe(16'h7777, 0, 1'b0);
        idle(12);

        check("queue_empty", wq.size(), 0);
        check("sample_pending", active, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
